// File: rtl/timer_array.sv
// NUM_CH independent programmable down-counters behind one bridge slot, 16 bytes per channel.
// Optional per-channel prescaler in CTRL[15:8] when TIMER_PRESCALE_EN is defined.
module timer_array #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, DONE} state_t;

  localparam logic [31:0]      SPAN    = 32'(16 * NUM_CH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0] offset;
  logic        hit;
  logic [2:0]  sel_ch;
  logic [1:0]  sel_reg;
  logic [31:0] rd_word [NUM_CH];
  logic        wdata_unused;

  assign offset       = addr - BASE_ADDR;
  assign hit          = (addr >= BASE_ADDR) && (offset < SPAN);
  assign sel_ch       = offset[6:4];
  assign sel_reg      = offset[3:2];
  assign wdata_unused = ^wdata;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           state_reg, state_next;
    logic             en_reg, im_reg, pend_reg;
    logic [1:0]       mode_reg;
    logic [CNT_W-1:0] preset_reg, count_reg;
    logic             ctrl_we, preset_we, auto_reload, tick;
    logic             do_load, do_dec, do_done;
    logic [7:0]       ps_field;
    logic [31:0]      ch_word;

    assign ctrl_we     = we && hit && (sel_ch == 3'(gi)) && (sel_reg == 2'd0);
    assign preset_we   = we && hit && (sel_ch == 3'(gi)) && (sel_reg == 2'd1);
    assign auto_reload = (mode_reg == 2'b01);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] ps_reg, pre_cnt_reg;

    assign tick     = (pre_cnt_reg == ps_reg);
    assign ps_field = ps_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        ps_reg      <= '0;
        pre_cnt_reg <= '0;
      end else begin
        if (ctrl_we) ps_reg <= wdata[15:8];
        if (do_load || !en_reg) pre_cnt_reg <= '0;
        else if (state_reg == CNT) pre_cnt_reg <= tick ? 8'd0 : pre_cnt_reg + 8'd1;
      end
    end
`else
    assign tick     = 1'b1;
    assign ps_field = 8'h00;
`endif

    always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
    end

    // A count of 0 or 1 expires on the next tick, so PRESET 0 behaves as 1.
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        IDLE:    if (en_reg) state_next = LOAD;
        LOAD:    state_next = CNT;
        CNT: begin
          if (!en_reg)                           state_next = IDLE;
          else if (tick && count_reg <= CNT_ONE) state_next = DONE;
        end
        DONE:    state_next = auto_reload ? LOAD : IDLE;
        default: state_next = IDLE;
      endcase
    end

    always_comb begin
      do_load = (state_reg == LOAD);
      do_dec  = (state_reg == CNT) && en_reg && tick;
      do_done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        en_reg     <= 1'b0;
        im_reg     <= 1'b0;
        pend_reg   <= 1'b0;
        mode_reg   <= 2'b00;
        preset_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_load)     count_reg <= preset_reg;
        else if (do_dec) count_reg <= (count_reg > CNT_ONE) ? count_reg - CNT_ONE : '0;

        if (preset_we) preset_reg <= wdata[CNT_W-1:0];

        // A bus write to CTRL overrides the one-shot auto-disable.
        if (ctrl_we) begin
          en_reg   <= wdata[0];
          mode_reg <= wdata[2:1];
          im_reg   <= wdata[3];
        end else if (do_done && !auto_reload) begin
          en_reg <= 1'b0;
        end

        if (do_done)                 pend_reg <= 1'b1;
        else if (ctrl_we && wdata[4]) pend_reg <= 1'b0;
      end
    end

    always_comb begin
      ch_word = '0;
      case (sel_reg)
        2'd0:    ch_word = {16'h0000, ps_field, 3'b000, pend_reg, im_reg, mode_reg, en_reg};
        2'd1:    ch_word = 32'(preset_reg);
        2'd2:    ch_word = 32'(count_reg);
        default: ch_word = '0;
      endcase
    end

    assign rd_word[gi] = ch_word;
    assign irq[gi]     = pend_reg & im_reg;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit && sel_ch == 3'(i)) rdata = rd_word[i];
    end
  end

  assign irq_any = |irq;

endmodule
